// File: rtl/issue_decode_queue_pkg.sv
// Shared constants and types for the issue-stage decode queue:
// RV32I/M opcode, funct3 and funct7 codes, instruction field positions,
// the decoded-op enumeration and the queued micro-op record.
package issue_decode_queue_pkg;

    localparam int OPENUM_WIDTH = 6;

    // Instruction field positions
    localparam int RD_LSB     = 7;
    localparam int FUNC3_LSB  = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNC7_LSB  = 25;

    // Major opcodes
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    // funct3 codes
    localparam logic [2:0] FUNC3_JALR = 3'b000;
    localparam logic [2:0] FUNC3_BEQ  = 3'b000;
    localparam logic [2:0] FUNC3_BNE  = 3'b001;
    localparam logic [2:0] FUNC3_BLT  = 3'b100;
    localparam logic [2:0] FUNC3_BGE  = 3'b101;
    localparam logic [2:0] FUNC3_BLTU = 3'b110;
    localparam logic [2:0] FUNC3_BGEU = 3'b111;
    localparam logic [2:0] FUNC3_LB   = 3'b000;
    localparam logic [2:0] FUNC3_LH   = 3'b001;
    localparam logic [2:0] FUNC3_LW   = 3'b010;
    localparam logic [2:0] FUNC3_LBU  = 3'b100;
    localparam logic [2:0] FUNC3_LHU  = 3'b101;
    localparam logic [2:0] FUNC3_SB   = 3'b000;
    localparam logic [2:0] FUNC3_SH   = 3'b001;
    localparam logic [2:0] FUNC3_SW   = 3'b010;
    localparam logic [2:0] FUNC3_ADD  = 3'b000;
    localparam logic [2:0] FUNC3_SLL  = 3'b001;
    localparam logic [2:0] FUNC3_SLT  = 3'b010;
    localparam logic [2:0] FUNC3_SLTU = 3'b011;
    localparam logic [2:0] FUNC3_XOR  = 3'b100;
    localparam logic [2:0] FUNC3_SRL  = 3'b101;
    localparam logic [2:0] FUNC3_OR   = 3'b110;
    localparam logic [2:0] FUNC3_AND  = 3'b111;

    // funct7 codes
    localparam logic [6:0] FUNC7_NORMAL = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    // Decoded op enumeration; the M-extension codes are appended at the end
    // and kept contiguous in funct3 order so MUL + funct3 selects the op.
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_NOP    = 6'd0;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LUI    = 6'd1;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_AUIPC  = 6'd2;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_JAL    = 6'd3;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_JALR   = 6'd4;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BEQ    = 6'd5;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BNE    = 6'd6;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BLT    = 6'd7;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BGE    = 6'd8;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BLTU   = 6'd9;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_BGEU   = 6'd10;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LB     = 6'd11;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LH     = 6'd12;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LW     = 6'd13;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LBU    = 6'd14;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_LHU    = 6'd15;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SB     = 6'd16;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SH     = 6'd17;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SW     = 6'd18;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ADDI   = 6'd19;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTI   = 6'd20;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTIU  = 6'd21;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_XORI   = 6'd22;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ORI    = 6'd23;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ANDI   = 6'd24;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLLI   = 6'd25;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRLI   = 6'd26;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRAI   = 6'd27;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_ADD    = 6'd28;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SUB    = 6'd29;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLL    = 6'd30;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLT    = 6'd31;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SLTU   = 6'd32;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_XOR    = 6'd33;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRL    = 6'd34;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_SRA    = 6'd35;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_OR     = 6'd36;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_AND    = 6'd37;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_MUL    = 6'd38;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_MULH   = 6'd39;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_MULHSU = 6'd40;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_MULHU  = 6'd41;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_DIV    = 6'd42;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_DIVU   = 6'd43;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_REM    = 6'd44;
    localparam logic [OPENUM_WIDTH-1:0] OPENUM_REMU   = 6'd45;

    // One queued micro-op
    typedef struct packed {
        logic [OPENUM_WIDTH-1:0] openum;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
        logic [31:0]             imm;
        logic                    is_jump;
        logic                    is_store;
        logic                    illegal;
        logic [31:0]             pc;
        logic                    pred_jump;
    } uop_t;

endpackage

// File: rtl/issue_decode_queue_decode.sv
// Combinational RV32I (+ optional RV32M) decoder. Fields a format lacks are
// forced to zero; any unrecognised encoding comes out as a NOP with illegal
// set and every other field cleared.
module rv32_decode_core
    import issue_decode_queue_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]             inst,
    output logic [OPENUM_WIDTH-1:0] openum,
    output logic [4:0]              rd,
    output logic [4:0]              rs1,
    output logic [4:0]              rs2,
    output logic [31:0]             imm,
    output logic                    is_jump,
    output logic                    is_store,
    output logic                    illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = inst[6:0];
    assign f3     = inst[FUNC3_LSB +: 3];
    assign f7     = inst[FUNC7_LSB +: 7];
    assign f_rd   = inst[RD_LSB +: 5];
    assign f_rs1  = inst[RS1_LSB +: 5];
    assign f_rs2  = inst[RS2_LSB +: 5];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Select op and fields per major opcode, then scrub everything on illegal
    always_comb begin
        openum   = OPENUM_NOP;
        rd       = '0;
        rs1      = '0;
        rs2      = '0;
        imm      = '0;
        is_jump  = 1'b0;
        is_store = 1'b0;
        illegal  = 1'b0;

        case (opcode)
            OPCODE_LUI: begin
                openum = OPENUM_LUI;
                rd     = f_rd;
                imm    = imm_u;
            end
            OPCODE_AUIPC: begin
                openum = OPENUM_AUIPC;
                rd     = f_rd;
                imm    = imm_u;
            end
            OPCODE_JAL: begin
                openum  = OPENUM_JAL;
                rd      = f_rd;
                imm     = imm_j;
                is_jump = 1'b1;
            end
            OPCODE_JALR: begin
                openum  = OPENUM_JALR;
                rd      = f_rd;
                rs1     = f_rs1;
                imm     = imm_i;
                is_jump = 1'b1;
                illegal = (f3 != FUNC3_JALR);
            end
            OPCODE_BRANCH: begin
                rs1     = f_rs1;
                rs2     = f_rs2;
                imm     = imm_b;
                is_jump = 1'b1;
                case (f3)
                    FUNC3_BEQ:  openum = OPENUM_BEQ;
                    FUNC3_BNE:  openum = OPENUM_BNE;
                    FUNC3_BLT:  openum = OPENUM_BLT;
                    FUNC3_BGE:  openum = OPENUM_BGE;
                    FUNC3_BLTU: openum = OPENUM_BLTU;
                    FUNC3_BGEU: openum = OPENUM_BGEU;
                    default:    illegal = 1'b1;
                endcase
            end
            OPCODE_LOAD: begin
                rd  = f_rd;
                rs1 = f_rs1;
                imm = imm_i;
                case (f3)
                    FUNC3_LB:  openum = OPENUM_LB;
                    FUNC3_LH:  openum = OPENUM_LH;
                    FUNC3_LW:  openum = OPENUM_LW;
                    FUNC3_LBU: openum = OPENUM_LBU;
                    FUNC3_LHU: openum = OPENUM_LHU;
                    default:   illegal = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                rs1      = f_rs1;
                rs2      = f_rs2;
                imm      = imm_s;
                is_store = 1'b1;
                case (f3)
                    FUNC3_SB: openum = OPENUM_SB;
                    FUNC3_SH: openum = OPENUM_SH;
                    FUNC3_SW: openum = OPENUM_SW;
                    default:  illegal = 1'b1;
                endcase
            end
            OPCODE_ARITHI: begin
                rd  = f_rd;
                rs1 = f_rs1;
                imm = imm_i;
                case (f3)
                    FUNC3_ADD:  openum = OPENUM_ADDI;
                    FUNC3_SLT:  openum = OPENUM_SLTI;
                    FUNC3_SLTU: openum = OPENUM_SLTIU;
                    FUNC3_XOR:  openum = OPENUM_XORI;
                    FUNC3_OR:   openum = OPENUM_ORI;
                    FUNC3_AND:  openum = OPENUM_ANDI;
                    FUNC3_SLL: begin
                        openum  = OPENUM_SLLI;
                        illegal = (f7 != FUNC7_NORMAL);
                    end
                    default: begin
                        // funct3 101: shift right, logical or arithmetic by funct7
                        if (f7 == FUNC7_NORMAL)
                            openum = OPENUM_SRLI;
                        else if (f7 == FUNC7_ALT)
                            openum = OPENUM_SRAI;
                        else
                            illegal = 1'b1;
                    end
                endcase
            end
            OPCODE_ARITH: begin
                rd  = f_rd;
                rs1 = f_rs1;
                rs2 = f_rs2;
                if (f7 == FUNC7_NORMAL) begin
                    case (f3)
                        FUNC3_ADD:  openum = OPENUM_ADD;
                        FUNC3_SLL:  openum = OPENUM_SLL;
                        FUNC3_SLT:  openum = OPENUM_SLT;
                        FUNC3_SLTU: openum = OPENUM_SLTU;
                        FUNC3_XOR:  openum = OPENUM_XOR;
                        FUNC3_SRL:  openum = OPENUM_SRL;
                        FUNC3_OR:   openum = OPENUM_OR;
                        default:    openum = OPENUM_AND;
                    endcase
                end else if (f7 == FUNC7_ALT) begin
                    if (f3 == FUNC3_ADD)
                        openum = OPENUM_SUB;
                    else if (f3 == FUNC3_SRL)
                        openum = OPENUM_SRA;
                    else
                        illegal = 1'b1;
                end else if (f7 == FUNC7_MULDIV && ENABLE_M) begin
                    openum = OPENUM_MUL + OPENUM_WIDTH'(f3);
                end else begin
                    illegal = 1'b1;
                end
            end
            OPCODE_FENCE: begin
                // Ordering is trivially satisfied in this pipeline: a legal NOP
                openum = OPENUM_NOP;
            end
            default: begin
                // Includes OPCODE_SYSTEM (ecall/ebreak/csr), not supported here
                illegal = 1'b1;
            end
        endcase

        if (illegal) begin
            openum   = OPENUM_NOP;
            rd       = '0;
            rs1      = '0;
            rs2      = '0;
            imm      = '0;
            is_jump  = 1'b0;
            is_store = 1'b0;
        end
    end

endmodule

// File: rtl/issue_decode_queue.sv
// Issue-stage front end: decodes fetched instructions on entry and buffers
// the micro-ops in a circular queue that feeds dispatch. rollback flushes
// the whole queue in one cycle; rdy=0 freezes everything.
module issue_decode_queue
    import issue_decode_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter bit ENABLE_M = 1'b0,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [31:0]         in_pc,
    input  logic                in_pred_jump,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPENUM_W-1:0] out_openum,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_imm,
    output logic                out_is_jump,
    output logic                out_is_store,
    output logic                out_illegal,
    output logic [31:0]         out_pc,
    output logic                out_pred_jump,
    output logic [ADDR_W:0]     count
);

    uop_t              entry_mem [DEPTH];
    logic [ADDR_W-1:0] head_reg;
    logic [ADDR_W-1:0] tail_reg;
    logic [ADDR_W:0]   count_reg;

    uop_t              new_uop;
    uop_t              head_uop;
    uop_t              shown_uop;
    logic              push;
    logic              pop;
    logic              has_data;

    rv32_decode_core #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .inst     (in_inst),
        .openum   (new_uop.openum),
        .rd       (new_uop.rd),
        .rs1      (new_uop.rs1),
        .rs2      (new_uop.rs2),
        .imm      (new_uop.imm),
        .is_jump  (new_uop.is_jump),
        .is_store (new_uop.is_store),
        .illegal  (new_uop.illegal)
    );

    assign new_uop.pc        = in_pc;
    assign new_uop.pred_jump = in_pred_jump;

    // No pop bypass: a full queue refuses input even while it is draining
    assign has_data  = (count_reg != '0);
    assign in_ready  = rdy & (count_reg < (ADDR_W+1)'(DEPTH));
    assign out_valid = rdy & has_data;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Pointer and occupancy update; rollback discards any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (rollback) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push)
                    tail_reg <= tail_reg + ADDR_W'(1);
                if (pop)
                    head_reg <= head_reg + ADDR_W'(1);
                if (push && !pop)
                    count_reg <= count_reg + (ADDR_W+1)'(1);
                else if (pop && !push)
                    count_reg <= count_reg - (ADDR_W+1)'(1);
            end
        end
    end

    // Entry storage write at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (!rst && !rollback && push)
            entry_mem[tail_reg] <= new_uop;
    end

    // Head entry presented combinationally; zeroed while the queue is empty
    always_comb begin
        head_uop  = entry_mem[head_reg];
        shown_uop = has_data ? head_uop : '0;
    end

    assign out_openum    = OPENUM_W'(shown_uop.openum);
    assign out_rd        = shown_uop.rd;
    assign out_rs1       = shown_uop.rs1;
    assign out_rs2       = shown_uop.rs2;
    assign out_imm       = shown_uop.imm;
    assign out_is_jump   = shown_uop.is_jump;
    assign out_is_store  = shown_uop.is_store;
    assign out_illegal   = shown_uop.illegal;
    assign out_pc        = shown_uop.pc;
    assign out_pred_jump = shown_uop.pred_jump;
    assign count         = count_reg;

endmodule

// File: tb/tb_issue_decode_queue.sv
// Scoreboard bench for issue_decode_queue. Two queues of depth 4 share all
// inputs: one decodes RV32M, the other treats it as illegal. Accepted
// instructions push their hand-computed micro-op into a per-DUT queue; a
// negedge monitor pops and compares whenever a DUT hands out its head entry.
module tb_issue_decode_queue;
    import issue_decode_queue_pkg::*;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        j;
        logic        s;
        logic        ill;
        logic [31:0] pc;
        logic        pj;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, in_valid, in_pred_jump, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        a_in_ready, a_out_valid, a_is_jump, a_is_store, a_illegal, a_pj;
    logic [5:0]  a_openum;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm, a_pc;
    logic [2:0]  a_count;
    logic        b_in_ready, b_out_valid, b_is_jump, b_is_store, b_illegal, b_pj;
    logic [5:0]  b_openum;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [31:0] b_imm, b_pc;
    logic [2:0]  b_count;

    exp_t obs_a, obs_b, pend_a, pend_b;
    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    issue_decode_queue #(.DEPTH(4), .ADDR_W(2), .ENABLE_M(1'b1), .OPENUM_W(6)) dut_a (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_jump(in_pred_jump), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_openum(a_openum), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_imm(a_imm), .out_is_jump(a_is_jump), .out_is_store(a_is_store),
        .out_illegal(a_illegal), .out_pc(a_pc), .out_pred_jump(a_pj), .count(a_count)
    );

    issue_decode_queue #(.DEPTH(4), .ADDR_W(2), .ENABLE_M(1'b0), .OPENUM_W(6)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_jump(in_pred_jump), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_openum(b_openum), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_imm(b_imm), .out_is_jump(b_is_jump), .out_is_store(b_is_store),
        .out_illegal(b_illegal), .out_pc(b_pc), .out_pred_jump(b_pj), .count(b_count)
    );

    assign obs_a = {a_openum, a_rd, a_rs1, a_rs2, a_imm, a_is_jump, a_is_store, a_illegal, a_pc, a_pj};
    assign obs_b = {b_openum, b_rd, b_rs1, b_rs2, b_imm, b_is_jump, b_is_store, b_illegal, b_pc, b_pj};

    function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [31:0] imm, input logic j, s, ill);
        exp_t e;
        e = '0;
        e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.j = j; e.s = s; e.ill = ill;
        return e;
    endfunction

    task automatic check_uop(input string tag, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h j=%b s=%b ill=%b pc=%h pj=%b required op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h j=%b s=%b ill=%b pc=%h pj=%b",
                     tag, got.op, got.rd, got.rs1, got.rs2, got.imm, got.j, got.s, got.ill, got.pc, got.pj,
                     want.op, want.rd, want.rs1, want.rs2, want.imm, want.j, want.s, want.ill, want.pc, want.pj);
        end else begin
            $display("ok   %s: pc=%h op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b",
                     tag, got.pc, got.op, got.rd, got.rs1, got.rs2, got.imm, got.ill);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", tag, got, want);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Monitor and acceptance tracker: pops are compared before this cycle's push is recorded
    always @(negedge clk) begin
        if (rst || (rdy && rollback)) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL a_unexpected_pop: got pc=%h required no entry", a_pc);
                end else begin
                    check_uop("a_pop", obs_a, qa.pop_front());
                end
            end
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL b_unexpected_pop: got pc=%h required no entry", b_pc);
                end else begin
                    check_uop("b_pop", obs_b, qb.pop_front());
                end
            end
            if (in_valid && a_in_ready) qa.push_back(pend_a);
            if (in_valid && b_in_ready) qb.push_back(pend_b);
        end
    end

    // Present an instruction with its expected decode for each DUT
    task automatic drive(input logic [31:0] inst, pc, input logic pj, input exp_t ea, eb);
        pend_a = ea; pend_a.pc = pc; pend_a.pj = pj;
        pend_b = eb; pend_b.pc = pc; pend_b.pj = pj;
        in_inst = inst; in_pc = pc; in_pred_jump = pj; in_valid = 1'b1;
    endtask

    // Drive until accepted (bounded); returns just after the accepting edge
    task automatic send(input logic [31:0] inst, pc, input logic pj, input exp_t ea, eb);
        bit done;
        done = 1'b0;
        drive(inst, pc, pj, ea, eb);
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: pc=%h got in_ready=0 required 1", pc);
        end
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = (a_count == 3'd0) && (b_count == 3'd0);
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: got count=%0d required 0", a_count);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t addi_exp(input int k);
        return mk(OPENUM_ADDI, 5'd1, 5'd0, 5'd0, 32'(k), 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] addi_inst(input int k);
        return (32'(k) << 20) | 32'h0000_0093;
    endfunction

    initial begin
        exp_t ill;
        ill = mk(OPENUM_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
        in_inst = '0; in_pc = '0; in_pred_jump = 1'b0; out_ready = 1'b0;
        pend_a = '0; pend_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_count", 32'(a_count), 32'd0);
        check("reset_out_valid", 32'(a_out_valid), 32'd0);
        check("reset_in_ready", 32'(a_in_ready), 32'd1);
        check("reset_payload", {a_openum, a_imm[25:0]}, 32'd0);
        check("reset_pc", a_pc, 32'd0);
        @(posedge clk); #1;

        // Decode vectors, streamed through with dispatch always ready
        out_ready = 1'b1;
        send(32'h00500093, 32'h100, 1'b0, mk(OPENUM_ADDI, 1, 0, 0, 32'd5, 0, 0, 0),
                                          mk(OPENUM_ADDI, 1, 0, 0, 32'd5, 0, 0, 0));
        check("latency_out_valid", 32'(a_out_valid), 32'd1);
        check("latency_count", 32'(a_count), 32'd1);
        send(32'hFE000EE3, 32'h104, 1'b1, mk(OPENUM_BEQ, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 0),
                                          mk(OPENUM_BEQ, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 0));
        send(32'h022081B3, 32'h108, 1'b0, mk(OPENUM_MUL, 3, 1, 2, 32'd0, 0, 0, 0), ill);
        send(32'h0220C1B3, 32'h10C, 1'b0, mk(OPENUM_DIV, 3, 1, 2, 32'd0, 0, 0, 0), ill);
        send(32'h00000073, 32'h110, 1'b0, ill, ill);
        send(32'h123452B7, 32'h114, 1'b0, mk(OPENUM_LUI, 5, 0, 0, 32'h12345000, 0, 0, 0),
                                          mk(OPENUM_LUI, 5, 0, 0, 32'h12345000, 0, 0, 0));
        send(32'h0020A423, 32'h118, 1'b0, mk(OPENUM_SW, 0, 1, 2, 32'd8, 0, 1, 0),
                                          mk(OPENUM_SW, 0, 1, 2, 32'd8, 0, 1, 0));
        send(32'h010000EF, 32'h11C, 1'b1, mk(OPENUM_JAL, 1, 0, 0, 32'd16, 1, 0, 0),
                                          mk(OPENUM_JAL, 1, 0, 0, 32'd16, 1, 0, 0));
        send(32'h402081B3, 32'h120, 1'b0, mk(OPENUM_SUB, 3, 1, 2, 32'd0, 0, 0, 0),
                                          mk(OPENUM_SUB, 3, 1, 2, 32'd0, 0, 0, 0));
        send(32'h4030D213, 32'h124, 1'b0, mk(OPENUM_SRAI, 4, 1, 0, 32'h403, 0, 0, 0),
                                          mk(OPENUM_SRAI, 4, 1, 0, 32'h403, 0, 0, 0));
        send(32'h0FF0000F, 32'h128, 1'b0, mk(OPENUM_NOP, 0, 0, 0, 32'd0, 0, 0, 0),
                                          mk(OPENUM_NOP, 0, 0, 0, 32'd0, 0, 0, 0));
        send(32'h00009067, 32'h12C, 1'b0, ill, ill);
        send(32'hFFC12283, 32'h130, 1'b0, mk(OPENUM_LW, 5, 2, 0, 32'hFFFFFFFC, 0, 0, 0),
                                          mk(OPENUM_LW, 5, 2, 0, 32'hFFFFFFFC, 0, 0, 0));
        send(32'h00002063, 32'h134, 1'b0, ill, ill);
        send(32'h00001397, 32'h138, 1'b0, mk(OPENUM_AUIPC, 7, 0, 0, 32'h1000, 0, 0, 0),
                                          mk(OPENUM_AUIPC, 7, 0, 0, 32'h1000, 0, 0, 0));
        wait_empty();

        // Fill to full, hold a fifth, free one slot, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(addi_inst(i + 1), 32'h200 + 32'(4 * i), 1'b0, addi_exp(i + 1), addi_exp(i + 1));
        @(negedge clk);
        check("full_count", 32'(a_count), 32'd4);
        check("full_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        drive(addi_inst(5), 32'h210, 1'b0, addi_exp(5), addi_exp(5));
        repeat (2) @(negedge clk);
        check("held_count", 32'(a_count), 32'd4);
        check("held_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_count", 32'(a_count), 32'd3);
        check("after_pop_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("refill_count", 32'(a_count), 32'd4);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_empty();

        // Steady push+pop at count=2, enough cycles to wrap the pointers
        out_ready = 1'b0;
        send(addi_inst(20), 32'h300, 1'b0, addi_exp(20), addi_exp(20));
        send(addi_inst(21), 32'h304, 1'b0, addi_exp(21), addi_exp(21));
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(addi_inst(k + 30), 32'h308 + 32'(4 * k), k[0], addi_exp(k + 30), addi_exp(k + 30));
            @(negedge clk);
            check("steady_count", 32'(a_count), 32'd2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("steady_final_count", 32'(a_count), 32'd2);
        wait_empty();

        // Rollback with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(addi_inst(i + 40), 32'h400 + 32'(4 * i), 1'b0, addi_exp(i + 40), addi_exp(i + 40));
        @(negedge clk);
        check("pre_rollback_count", 32'(a_count), 32'd3);
        @(posedge clk); #1;
        drive(addi_inst(50), 32'h4F0, 1'b0, addi_exp(50), addi_exp(50));
        rollback = 1'b1;
        @(negedge clk);
        check("rollback_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1 rollback = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rollback_count", 32'(a_count), 32'd0);
        check("rollback_out_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        send(addi_inst(51), 32'h500, 1'b0, addi_exp(51), addi_exp(51));
        wait_empty();

        // Reset mid-stream with a concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(addi_inst(i + 60), 32'h600 + 32'(4 * i), 1'b0, addi_exp(i + 60), addi_exp(i + 60));
        drive(addi_inst(63), 32'h6F0, 1'b0, addi_exp(63), addi_exp(63));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;

        // rdy=0 freezes state and ignores rollback
        send(addi_inst(70), 32'h700, 1'b0, addi_exp(70), addi_exp(70));
        send(addi_inst(71), 32'h704, 1'b1, addi_exp(71), addi_exp(71));
        rdy = 1'b0; rollback = 1'b1; out_ready = 1'b1;
        drive(addi_inst(72), 32'h7F0, 1'b0, addi_exp(72), addi_exp(72));
        @(negedge clk);
        check("frozen_in_ready", 32'(a_in_ready), 32'd0);
        check("frozen_out_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1 rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("frozen_count", 32'(a_count), 32'd2);
        check("frozen_count_b", 32'(b_count), 32'd2);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_empty();

        check("scoreboard_a_empty", 32'(qa.size()), 32'd0);
        check("scoreboard_b_empty", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
